// File: rtl/count_enable_ctrl_if.sv
// Button/mode inputs and count-enable outputs between the control stage and its driver.
interface count_enable_ctrl_if;
    logic btn_in;
    logic mode;
    logic en;
    logic running;

    modport master (
        output btn_in,
        output mode,
        input  en,
        input  running
    );

    modport slave (
        input  btn_in,
        input  mode,
        output en,
        output running
    );
endinterface

// File: rtl/count_enable_ctrl.sv
// Produces the single-cycle count-enable strobe for the up counter from a raw push-button:
// synchronise, debounce, then either step once per press or free-run every PRESCALE clocks.
module count_enable_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 4,
    parameter int unsigned PRESCALE        = 8,
    parameter int unsigned CNT_W           = 16
) (
    input logic                clk,
    input logic                rst,
    count_enable_ctrl_if.slave bus
);

    localparam logic [0:0] S_IDLE = 1'b0;
    localparam logic [0:0] S_TICK = 1'b1;

    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] PS_LAST = CNT_W'(PRESCALE - 1);

    logic             sync1;
    logic             sync2;
    logic             db;
    logic             db_prev;
    logic [CNT_W-1:0] db_cnt;
    logic [CNT_W-1:0] ps_cnt;
    logic [0:0]       state;
    logic             en_q;
    logic             press;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1 <= 1'b0;
            sync2 <= 1'b0;
        end else begin
            sync1 <= bus.btn_in;
            sync2 <= sync1;
        end
    end

    // db flips only after DEBOUNCE_CYCLES consecutive mismatching samples; any agreement restarts.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            db      <= 1'b0;
            db_prev <= 1'b0;
            db_cnt  <= '0;
        end else begin
            db_prev <= db;
            if (sync2 != db) begin
                if (db_cnt == DB_LAST) begin
                    db     <= sync2;
                    db_cnt <= '0;
                end else begin
                    db_cnt <= db_cnt + CNT_W'(1);
                end
            end else begin
                db_cnt <= '0;
            end
        end
    end

    assign press = db & ~db_prev;

    // Mode is sampled on the same edge as the press, so a press during a mode change obeys the new mode.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= S_IDLE;
            ps_cnt <= '0;
            en_q   <= 1'b0;
        end else if (!bus.mode) begin
            state  <= S_IDLE;
            ps_cnt <= '0;
            en_q   <= press;
        end else begin
            case (state)
                S_IDLE: begin
                    ps_cnt <= '0;
                    en_q   <= 1'b0;
                    if (press) begin
                        state <= S_TICK;
                    end
                end
                S_TICK: begin
                    if (press) begin
                        state  <= S_IDLE;
                        ps_cnt <= '0;
                        en_q   <= 1'b0;
                    end else if (ps_cnt == PS_LAST) begin
                        ps_cnt <= '0;
                        en_q   <= 1'b1;
                    end else begin
                        ps_cnt <= ps_cnt + CNT_W'(1);
                        en_q   <= 1'b0;
                    end
                end
                default: begin
                    state  <= S_IDLE;
                    ps_cnt <= '0;
                    en_q   <= 1'b0;
                end
            endcase
        end
    end

    assign bus.en      = en_q;
    assign bus.running = (state == S_TICK);

endmodule

// File: tb/tb_count_enable_ctrl.sv
// Directed bench for count_enable_ctrl with DEBOUNCE_CYCLES=4 and PRESCALE=3.
module tb_count_enable_ctrl;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    count_enable_ctrl_if bus ();

    count_enable_ctrl #(
        .DEBOUNCE_CYCLES(4),
        .PRESCALE       (3),
        .CNT_W          (16)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // Hold btn_in at lvl for n edges; j=0 is the first edge sampling the level.
    task automatic drive_btn(input logic lvl, input int n, input int en_at, input string tag);
        bus.btn_in = lvl;
        for (int j = 0; j < n; j++) begin
            step();
            chk(tag, bus.en, (j == en_at));
            chk(tag, bus.running, 1'b0);
        end
    endtask

    // Run-mode sequence: start press at t=0, second press at s_stop, optional mode drop at m_drop.
    task automatic run_seq(input int s_stop, input int m_drop, input int t_end, input string tag);
        int   stop_t;
        int   end_run;
        logic exp_run;
        logic exp_en;
        stop_t  = s_stop + 6;
        end_run = (m_drop >= 0 && m_drop < stop_t) ? m_drop : stop_t;
        for (int t = 0; t < t_end; t++) begin
            bus.btn_in = (t < 10) || (t >= s_stop && t < s_stop + 10);
            if (m_drop >= 0 && t == m_drop) bus.mode = 1'b0;
            step();
            exp_run = (t >= 6 && t < end_run);
            exp_en  = (t > 6 && t < end_run && (t - 6) % 3 == 0)
                    || (m_drop >= 0 && m_drop <= stop_t && t == stop_t);
            chk({tag, "_running"}, bus.running, exp_run);
            chk({tag, "_en"}, bus.en, exp_en);
        end
    endtask

    initial begin
        n_tests    = 0;
        n_fail     = 0;
        rst        = 1'b0;
        bus.mode   = 1'b0;
        bus.btn_in = 1'b0;

        // Reset held with a toggling button
        for (int i = 0; i < 6; i++) begin
            bus.btn_in = (i % 2 == 0);
            step();
            chk("rst_en", bus.en, 1'b0);
            chk("rst_running", bus.running, 1'b0);
        end
        rst = 1'b1;
        drive_btn(1'b0, 5, -1, "post_rst_idle");

        // Clean step press: en exactly 6 edges after the first high sample
        drive_btn(1'b1, 20, 6, "step_press");
        drive_btn(1'b0, 15, -1, "step_release");

        // Bounce rejection
        drive_btn(1'b1, 3, -1, "bounce_h3");
        drive_btn(1'b0, 1, -1, "bounce_l1");
        drive_btn(1'b1, 2, -1, "bounce_h2");
        drive_btn(1'b0, 1, -1, "bounce_l1b");
        drive_btn(1'b1, 10, 6, "bounce_final");
        drive_btn(1'b0, 15, -1, "bounce_release");

        // Step press then run start/stop (stop off a wrap edge)
        drive_btn(1'b1, 10, 6, "run_step_press");
        drive_btn(1'b0, 15, -1, "run_step_release");
        bus.mode = 1'b1;
        drive_btn(1'b0, 3, -1, "run_idle");
        run_seq(20, -1, 45, "run_startstop");

        // Stop press landing on a wrap edge
        run_seq(21, -1, 45, "stop_on_wrap");

        // Mode drop on a wrap edge, then a step press
        run_seq(25, 12, 45, "mode_drop");
        drive_btn(1'b0, 5, -1, "mode_drop_after");

        // Asynchronous reset while en is high, then re-debounce after release
        bus.mode   = 1'b1;
        bus.btn_in = 1'b1;
        for (int j = 0; j < 10; j++) begin
            step();
            chk("pre_rst_running", bus.running, (j >= 6));
            chk("pre_rst_en", bus.en, (j == 9));
        end
        rst = 1'b0;
        #1;
        chk("async_rst_en", bus.en, 1'b0);
        chk("async_rst_running", bus.running, 1'b0);
        for (int j = 0; j < 3; j++) begin
            step();
            chk("rst_hold_running", bus.running, 1'b0);
        end
        rst = 1'b1;
        for (int j = 0; j < 9; j++) begin
            step();
            chk("redebounce_running", bus.running, (j >= 6));
            chk("redebounce_en", bus.en, 1'b0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/count_enable_ctrl.md
Name: count_enable_ctrl

Overview:
Upstream control stage that produces the single-cycle `en` strobe consumed by the 8-bit up counter.
- Takes a raw, asynchronous push-button input.
- Synchronises and debounces it.
- Step mode: one `en` pulse per press.
- Run mode: free-running `en` ticks every PRESCALE clocks, started and stopped by successive presses.

Parameters:
DEBOUNCE_CYCLES, 4, consecutive synchronised cycles of a changed level required before the debounced level flips (>=2)
PRESCALE, 8, clock cycles between `en` pulses in run mode (>=2)
CNT_W, 16, width of debounce and prescale counters; must hold max(DEBOUNCE_CYCLES, PRESCALE)

Ports:
clk      input   1      single system clock, rising-edge
rst      input   1      asynchronous, active-low reset (rst=0 resets all state immediately)
btn_in   input   1      raw button, asynchronous to clk, active-high, may bounce
mode     input   1      0 = step mode, 1 = run mode; synchronous to clk
en       output  1      count-enable strobe to the up counter; registered
running  output  1      1 while run mode is actively ticking; registered

Behaviour:
- Reset (rst low, async): all flops cleared.
  - en=0, running=0.
  - Synchroniser=0, debounced level=0.
  - Debounce counter=0, prescale counter=0.
  - Release of rst is synchronous in effect; the first active edge after release evaluates normally.
- Synchroniser: two-flop chain on btn_in (sync1, sync2). Only sync2 feeds downstream logic.
- Debouncer:
  - Holds register db.
  - If sync2 != db: counter increments. When counter == DEBOUNCE_CYCLES-1 and a mismatch is still present, db takes sync2 and the counter clears on that same edge.
  - If sync2 == db: counter clears. Any bounce restarts the count.
- Press event: registered rising edge of db (db=1 and db_prev=0), valid for exactly one cycle.
- Latency: btn_in first sampled high at edge k and held stable gives:
  - db=1 at edge k+1+DEBOUNCE_CYCLES.
  - Press event at edge k+2+DEBOUNCE_CYCLES.
  - Releases produce no event.
- Step mode (mode=0):
  - en=1 for exactly one cycle, on the same edge as the press event.
  - running stays 0; the prescaler is held at 0.
- Run mode (mode=1), two-state FSM:
  - IDLE: running=0, en=0, prescaler=0. A press event moves to TICK and sets running=1 on that edge.
  - TICK: prescaler counts 0..PRESCALE-1 and wraps to 0. en=1 on the edge where the prescaler wraps, so the first en comes PRESCALE cycles after running rises, then every PRESCALE cycles.
  - A press event in TICK returns to IDLE. running=0, prescaler=0 and en=0 on that edge, even if a wrap coincides (stop wins).
- Mode change:
  - mode 1->0 while in TICK forces IDLE on the next edge (running=0, en=0, prescaler=0).
  - mode 0->1 enters IDLE; no auto-start.
  - A press event on the same edge as a mode change is interpreted under the new mode value.
- Reset mid-operation: any state aborts immediately; a pending debounce count is lost, and the button must be re-debounced after reset release.
- en is never high for two consecutive cycles unless PRESCALE would allow it; PRESCALE>=2 guarantees single-cycle pulses.

Test Plan:
1. Reset check: DEBOUNCE_CYCLES=4. Hold rst=0 with btn_in=1 toggling -> en=0, running=0; assert rst=0 mid-count and check en/running drop asynchronously, before the next clk edge.
2. Clean step press: mode=0, btn_in 0->1 first sampled at edge 10, held 20 cycles -> db=1 at edge 15, en=1 only in the cycle after edge 16; no en on release.
3. Bounce rejection: mode=0, btn_in high 3 cycles, low 1, high 2, low 1, high 10 -> exactly one en pulse, 6 edges after the final stable-high sample.
4. Run start/stop: mode=0 for the first press, then mode=1 before the second press; PRESCALE=3 -> one step-mode en pulse; the run-mode press sets running=1, then en pulses at +3, +6, +9 cycles; a further press clears running and en stays 0 afterwards.
5. Stop coinciding with wrap: PRESCALE=3 in TICK, press event on a wrap edge -> running=0 and en=0 on that edge.
6. Mode drop while running: mode 1->0 in TICK -> running=0, en=0 next edge; a subsequent press yields one step pulse only.
